srt4_div_iter: RTL and testbench

- Radix-4 SRT mantissa divider iteration core for the FP32 divider. It sits between operand unpack/normalise and round/pack.
- Each cycle it forms the remainder/divisor indices, feeds them to the existing quotient digit selection table (qds), and updates the partial remainder.
- Digits are accumulated by on-the-fly conversion. A final correction step outputs the truncated quotient and a sticky bit.

---
 rtl/srt4_div_iter.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_srt4_div_iter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srt4_div_iter.sv
// ---------------------------------------------------------------------------
// srt4_div_iter
//
// Radix-4 SRT mantissa divider iteration core for the FP32 divider. It sits
// between operand unpack/normalise and round/pack. One quotient digit in
// {-2..+2} is retired per cycle. Digits are accumulated by on-the-fly
// conversion, and a final correction cycle produces the truncated quotient
// and a sticky bit.
//
// Result: quo * 2^-(2*ITER) = mant_a / (4*mant_b), truncated. sticky is set
// when the exact remainder is nonzero.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous reset, active-high
//   in_valid   in   operand pair valid
//   in_ready   out  core idle, can accept operands
//   mant_a     in   dividend mantissa (1.23 format, msb=1)
//   mant_b     in   divisor mantissa (1.23 format, msb=1)
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   quo        out  truncated quotient, 2*ITER fraction bits
//   sticky     out  final remainder nonzero
//
// Optional feature (macro SRT_DIV_EARLY_TERM_EN):
//   When defined, an iteration that leaves an exactly zero remainder ends
//   the division early. The remaining digits are known to be zero, so Q and
//   QM are shifted into final position and the core goes straight to the
//   correction cycle. Results are bit-identical, and only latency changes.
// ---------------------------------------------------------------------------
module srt4_div_iter #(
   parameter int MANT_W = 24,
   parameter int ITER   = 14
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [MANT_W-1:0]   mant_a,
   input  logic [MANT_W-1:0]   mant_b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2*ITER-1:0]   quo,
   output logic                sticky
);

   // Remainder format: sign, two integer bits, WF fraction bits.
   localparam int WF    = MANT_W + 3;
   localparam int WW    = WF + 3;
   localparam int QW    = 2 * ITER;
   localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ITER,
      S_FIX,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [WF-1:0]      d_q, d_d;
   logic [WW-1:0]      w_q, w_d;
   logic [QW-1:0]      qAcc_q, qAcc_d;
   logic [QW-1:0]      qmAcc_q, qmAcc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [QW-1:0]      quo_q, quo_d;
   logic               sticky_q, sticky_d;

   logic [WW-1:0]      dExt;
   logic [WW-1:0]      w4;
   logic [4:0]         rIdx;
   logic [4:0]         dIdx;
   logic [2:0]         qCode;
   logic [WW-1:0]      mult;
   logic               subMult;
   logic [WW-1:0]      wNext;
   logic [QW-1:0]      qNext, qmNext;
   logic               lastIter;

   // Quotient digit selection table. The remainder estimate y is in units of
   // 1/8 (signed), the divisor estimate is 1xxx in units of 1/16. Each digit
   // boundary m_k is the smallest multiple of 1/8 at or above the lower bound
   // (k-2/3)*d over the whole divisor interval; such a point always lies
   // below the upper bound of digit k-1, which keeps |w| <= 2/3*d.
   // Codes: 000=0, 001=+1, 010=+2, 111=-1, 110=-2.
   function automatic logic [2:0] qds(input logic [4:0] rIdxIn, input logic [4:0] dIdxIn);
      logic signed [5:0] y;
      logic signed [5:0] m1;
      logic signed [5:0] m2;
      y  = 6'(signed'(rIdxIn));
      m1 = 6'sd2;
      m2 = 6'sd6;
      case (dIdxIn[3:0])
         4'd8:    begin m1 = 6'sd2; m2 = 6'sd6;  end
         4'd9:    begin m1 = 6'sd2; m2 = 6'sd7;  end
         4'd10:   begin m1 = 6'sd2; m2 = 6'sd8;  end
         4'd11:   begin m1 = 6'sd2; m2 = 6'sd8;  end
         4'd12:   begin m1 = 6'sd3; m2 = 6'sd9;  end
         4'd13:   begin m1 = 6'sd3; m2 = 6'sd10; end
         4'd14:   begin m1 = 6'sd3; m2 = 6'sd10; end
         4'd15:   begin m1 = 6'sd3; m2 = 6'sd11; end
         default: begin m1 = 6'sd2; m2 = 6'sd6;  end
      endcase
      if (y >= m2)
         qds = 3'b010;
      else if (y >= m1)
         qds = 3'b001;
      else if (y >= -m1)
         qds = 3'b000;
      else if (y >= -m2)
         qds = 3'b111;
      else
         qds = 3'b110;
   endfunction

   // Index formation and remainder update. 4w drops the top two bits of w,
   // which are pure sign extension because |w| < 1. The r index is 4w
   // truncated to 1/8 and saturated to +/-1.875 outside [-2, 2), so the
   // table only ever sees a 5-bit estimate. The new remainder is a single
   // full-width add of +/-d or +/-2d.
   always_comb begin
      dExt     = {3'b000, d_q};
      w4       = {w_q[WW-3:0], 2'b00};
      dIdx     = {1'b0, d_q[WF-1:WF-4]};
      rIdx     = {w4[WW-1], w4[WW-3:WW-6]};
      if (!w4[WW-1] && w4[WW-2])
         rIdx = 5'b01111;
      else if (w4[WW-1] && !w4[WW-2])
         rIdx = 5'b10001;
      qCode    = qds(rIdx, dIdx);
      mult     = '0;
      subMult  = 1'b0;
      case (qCode)
         3'b001:  begin mult = dExt;        subMult = 1'b1; end
         3'b010:  begin mult = dExt << 1;   subMult = 1'b1; end
         3'b111:  begin mult = dExt;        subMult = 1'b0; end
         3'b110:  begin mult = dExt << 1;   subMult = 1'b0; end
         default: begin mult = '0;          subMult = 1'b0; end
      endcase
      wNext    = w4 + (subMult ? ~mult : mult) + WW'(subMult);
   end

   // On-the-fly conversion. Q holds the digits so far, QM holds Q minus one
   // unit in the last place, so a negative digit never needs a carry chain.
   always_comb begin
      qNext  = {qAcc_q[QW-3:0], 2'b00};
      qmNext = {qmAcc_q[QW-3:0], 2'b11};
      case (qCode)
         3'b001: begin
            qNext  = {qAcc_q[QW-3:0], 2'b01};
            qmNext = {qAcc_q[QW-3:0], 2'b00};
         end
         3'b010: begin
            qNext  = {qAcc_q[QW-3:0], 2'b10};
            qmNext = {qAcc_q[QW-3:0], 2'b01};
         end
         3'b111: begin
            qNext  = {qmAcc_q[QW-3:0], 2'b11};
            qmNext = {qmAcc_q[QW-3:0], 2'b10};
         end
         3'b110: begin
            qNext  = {qmAcc_q[QW-3:0], 2'b10};
            qmNext = {qmAcc_q[QW-3:0], 2'b01};
         end
         default: begin
            qNext  = {qAcc_q[QW-3:0], 2'b00};
            qmNext = {qmAcc_q[QW-3:0], 2'b11};
         end
      endcase
   end

   // Next-state and datapath control. Defaults hold every register, so only
   // the state that owns a register ever changes it.
   always_comb begin
      state_d  = state_q;
      d_d      = d_q;
      w_d      = w_q;
      qAcc_d   = qAcc_q;
      qmAcc_d  = qmAcc_q;
      cnt_d    = cnt_q;
      quo_d    = quo_q;
      sticky_d = sticky_q;
      lastIter = (cnt_q == CNT_LAST);
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               d_d     = {mant_b, 3'b000};
               w_d     = WW'(mant_a) << 1;
               qAcc_d  = '0;
               qmAcc_d = '0;
               cnt_d   = '0;
               state_d = S_ITER;
            end
         end
         S_ITER: begin
            w_d     = wNext;
            qAcc_d  = qNext;
            qmAcc_d = qmNext;
            cnt_d   = cnt_q + CNT_W'(1);
`ifdef SRT_DIV_EARLY_TERM_EN
            // Zero remainder: all later digits are zero, so place the digits
            // at their final weight now (QM gets the matching trailing ones).
            if (wNext == '0 && !lastIter) begin
               qAcc_d  = qNext << (2 * (ITER - 1 - int'(cnt_q)));
               qmAcc_d = (qmNext << (2 * (ITER - 1 - int'(cnt_q))))
                       | ~({QW{1'b1}} << (2 * (ITER - 1 - int'(cnt_q))));
               state_d = S_FIX;
            end
`endif
            if (lastIter)
               state_d = S_FIX;
         end
         S_FIX: begin
            // A negative final remainder means the last digit overshot: the
            // true quotient is QM and the corrected remainder w+d is nonzero.
            if (w_q[WW-1]) begin
               quo_d    = qmAcc_q;
               sticky_d = 1'b1;
            end else begin
               quo_d    = qAcc_q;
               sticky_d = (w_q != '0);
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready)
               state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset discards any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         d_q      <= '0;
         w_q      <= '0;
         qAcc_q   <= '0;
         qmAcc_q  <= '0;
         cnt_q    <= '0;
         quo_q    <= '0;
         sticky_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         d_q      <= d_d;
         w_q      <= w_d;
         qAcc_q   <= qAcc_d;
         qmAcc_q  <= qmAcc_d;
         cnt_q    <= cnt_d;
         quo_q    <= quo_d;
         sticky_q <= sticky_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign quo       = quo_q;
   assign sticky    = sticky_q;

   // Convergence checks: the digit code must be one the table defines, and
   // the remainder must stay inside the redundancy bound |w| <= 2/3*d.
   logic [WW-1:0]   absW;
   logic [WW+1:0]   absW3;
   logic [WW+1:0]   dTwice;

   always_comb begin
      absW   = w_q[WW-1] ? (~w_q + WW'(1)) : w_q;
      absW3  = (WW+2)'(absW) * (WW+2)'(3);
      dTwice = (WW+2)'(dExt) << 1;
   end

   always_ff @(posedge clk) begin
      if (!rst && state_q == S_ITER) begin
         assert (qCode == 3'b000 || qCode == 3'b001 || qCode == 3'b010 ||
                 qCode == 3'b111 || qCode == 3'b110)
            else $error("srt4_div_iter: illegal quotient digit code %b", qCode);
      end
      if (!rst && (state_q == S_ITER || state_q == S_FIX)) begin
         assert (absW3 <= dTwice)
            else $error("srt4_div_iter: remainder bound violated");
      end
   end

endmodule

// File: tb/tb_srt4_div_iter.sv
// ---------------------------------------------------------------------------
// tb_srt4_div_iter
//
// Self-checking bench for srt4_div_iter. Reference results come from plain
// integer division: quo = floor(mant_a * 2^26 / mant_b), sticky = nonzero
// remainder. Directed vectors, random operands, output back-pressure,
// back-to-back issue and a reset in the middle of an operation.
// ---------------------------------------------------------------------------
module tb_srt4_div_iter;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [23:0]   mant_a;
   logic [23:0]   mant_b;
   logic          out_valid;
   logic          out_ready;
   logic [27:0]   quo;
   logic          sticky;

   int nChecks = 0;
   int nPass   = 0;

   srt4_div_iter #(
      .MANT_W (24),
      .ITER   (14)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mant_a    (mant_a),
      .mant_b    (mant_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quo       (quo),
      .sticky    (sticky)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: exact quotient of mant_a / (4*mant_b) scaled by 2^28.
   function automatic void model(input logic [23:0] a, input logic [23:0] b,
                                 output logic [27:0] q, output logic s);
      longint num;
      longint den;
      num = longint'(a) << 26;
      den = longint'(b);
      q   = 28'(num / den);
      s   = (num % den) != 0;
   endfunction

   // Issue one operation starting at a negedge and collect its result.
   // lat counts clock edges from the accept edge through the edge that
   // raises out_valid, inclusive. Returns at a negedge after the handshake.
   task automatic runOp(input logic [23:0] a, input logic [23:0] b,
                        output logic [27:0] q, output logic s,
                        output int lat, output int waitCyc, output bit timedOut);
      timedOut = 1'b0;
      waitCyc  = 0;
      lat      = 0;
      mant_a   = a;
      mant_b   = b;
      in_valid = 1'b1;
      while (!in_ready && waitCyc < 50) begin
         @(posedge clk);
         @(negedge clk);
         waitCyc++;
      end
      if (!in_ready) timedOut = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      if (!out_valid) timedOut = 1'b1;
      q = quo;
      s = sticky;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   function automatic bit latencyOk(input int lat);
`ifdef SRT_DIV_EARLY_TERM_EN
      return (lat >= 3 && lat <= 16);
`else
      return (lat == 16);
`endif
   endfunction

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      mant_a    = '0;
      mant_b    = '0;
      repeat (3) @(negedge clk);
      nChecks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || quo !== 28'h0 || sticky !== 1'b0)
         $display("[TB] FAIL reset_state: in_ready=%b out_valid=%b quo=%h sticky=%b, want 1 0 0 0",
                  in_ready, out_valid, quo, sticky);
      else nPass++;
      rst = 1'b0;
      @(negedge clk);
      nChecks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("[TB] FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      else nPass++;
   endtask

   task automatic test_directed();
      logic [23:0] va [4];
      logic [23:0] vb [4];
      logic [27:0] vq [4];
      logic        vs [4];
      logic [27:0] q, mq;
      logic        s, ms;
      int          lat, waitCyc;
      bit          to;
      va = '{24'h800000, 24'hC00000, 24'h800000, 24'hFFFFFF};
      vb = '{24'h800000, 24'h800000, 24'hC00000, 24'h800000};
      vq = '{28'h4000000, 28'h6000000, 28'h2AAAAAA, 28'h7FFFFF8};
      vs = '{1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         runOp(va[i], vb[i], q, s, lat, waitCyc, to);
         model(va[i], vb[i], mq, ms);
         nChecks++;
         if (to || q !== vq[i] || s !== vs[i] || mq !== vq[i])
            $display("[TB] FAIL directed_%0d: quo=%h sticky=%b timeout=%b, want quo=%h sticky=%b",
                     i, q, s, to, vq[i], vs[i]);
         else nPass++;
         nChecks++;
         if (!latencyOk(lat))
            $display("[TB] FAIL directed_latency_%0d: latency=%0d, want 16 (3..16 with early term)", i, lat);
         else nPass++;
      end
   endtask

   task automatic test_random();
      logic [23:0] a, b;
      logic [27:0] q, mq;
      logic        s, ms;
      int          lat, waitCyc;
      bit          to;
      for (int i = 0; i < 40; i++) begin
         a = 24'h800000 | 24'($urandom);
         b = 24'h800000 | 24'($urandom);
         if (i % 8 == 0) a = b;
         if (i % 8 == 1) a = 24'h800000;
         runOp(a, b, q, s, lat, waitCyc, to);
         model(a, b, mq, ms);
         nChecks++;
         if (to || q !== mq || s !== ms || !latencyOk(lat))
            $display("[TB] FAIL random_%0d: a=%h b=%h quo=%h sticky=%b lat=%0d to=%b, want quo=%h sticky=%b",
                     i, a, b, q, s, lat, to, mq, ms);
         else nPass++;
      end
   endtask

   task automatic test_hold();
      logic [27:0] q0, mq;
      logic        s0, ms;
      int          cyc;
      mant_a   = 24'h800000;
      mant_b   = 24'hC00000;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      nChecks++;
      if (!out_valid)
         $display("[TB] FAIL hold_wait: out_valid=%b, want 1", out_valid);
      else nPass++;
      q0 = quo;
      s0 = sticky;
      // Offer a second operation that must not be taken while DONE is held.
      mant_a   = 24'hC00000;
      mant_b   = 24'h800000;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         nChecks++;
         if (quo !== 28'h2AAAAAA || sticky !== 1'b1 || quo !== q0 || sticky !== s0 ||
             in_ready !== 1'b0 || out_valid !== 1'b1)
            $display("[TB] FAIL hold_cycle_%0d: quo=%h sticky=%b in_ready=%b out_valid=%b, want 2aaaaaa 1 0 1",
                     i, quo, sticky, in_ready, out_valid);
         else nPass++;
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      nChecks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("[TB] FAIL hold_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      else nPass++;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      nChecks++;
      if (in_ready !== 1'b0)
         $display("[TB] FAIL hold_accept: in_ready=%b, want 0", in_ready);
      else nPass++;
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      model(24'hC00000, 24'h800000, mq, ms);
      nChecks++;
      if (!out_valid || quo !== mq || sticky !== ms)
         $display("[TB] FAIL hold_second_op: out_valid=%b quo=%h sticky=%b, want 1 %h %b",
                  out_valid, quo, sticky, mq, ms);
      else nPass++;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [23:0] a, b;
      logic [27:0] q, mq;
      logic        s, ms;
      int          lat, waitCyc;
      bit          to;
      for (int i = 0; i < 4; i++) begin
         a = 24'h800000 | 24'($urandom);
         b = 24'h800000 | 24'($urandom);
         runOp(a, b, q, s, lat, waitCyc, to);
         model(a, b, mq, ms);
         nChecks++;
         if (to || waitCyc != 0 || q !== mq || s !== ms)
            $display("[TB] FAIL back_to_back_%0d: quo=%h sticky=%b wait=%0d to=%b, want quo=%h sticky=%b wait=0",
                     i, q, s, waitCyc, to, mq, ms);
         else nPass++;
      end
   endtask

   task automatic test_reset_midop();
      logic [27:0] q;
      logic        s;
      int          lat, waitCyc;
      bit          to;
      bit          sawValid;
      mant_a   = 24'h800000;
      mant_b   = 24'hC00000;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      nChecks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("[TB] FAIL reset_midop: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      else nPass++;
      @(negedge clk);
      rst = 1'b0;
      sawValid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid || !in_ready) sawValid = 1'b1;
      end
      nChecks++;
      if (sawValid)
         $display("[TB] FAIL reset_discard: stale operation reappeared (sawValid=%b), want 0", sawValid);
      else nPass++;
      runOp(24'hC00000, 24'h800000, q, s, lat, waitCyc, to);
      nChecks++;
      if (to || q !== 28'h6000000 || s !== 1'b0)
         $display("[TB] FAIL reset_next_op: quo=%h sticky=%b to=%b, want 6000000 0", q, s, to);
      else nPass++;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_hold();
      test_back_to_back();
      test_reset_midop();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", nPass, nChecks);
      $fatal(1, "[TB] watchdog");
   end

endmodule
